rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised successor to the datapath 2:1 word mux.
- Selects one of N WIDTH-bit source channels onto a single registered output bus.
- Selection uses round-robin arbitration with valid/ready handshakes on every port.
- Sits between multiple datapath producers (register-file read, ALU result, immediate, memory load) and a shared bus consumer.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 16, data word width in bits.
- SEL_W, $clog2(N), width of channel index (derived localparam, not overridden).

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Resetn  input  1  synchronous, active-low reset.
- In_valid  input  N  bit i: channel i presents a word.
- In_data  input  N*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
- In_ready  output  N  bit i: channel i word accepted this cycle.
- Out_valid  output  1  output register holds a word.
- Out_data  output  WIDTH  registered selected word.
- Out_sel  output  SEL_W  index of the channel that supplied Out_data.
- Out_ready  input  1  consumer accepts Out_data this cycle.

Behaviour:
- Reset (Resetn=0 at a rising edge): Out_valid=0, Out_data=0, Out_sel=0, round-robin pointer ptr=0.
- While Resetn=0, In_ready = all zeros (combinational gating).
- A word in flight at reset is dropped.
- Free: free = ~Out_valid | Out_ready.
- Grant (combinational):
  - Scan channels ptr, ptr+1, ..., ptr+N-1 (mod N).
  - The first channel with In_valid=1 is the grant g.
  - No valid channel means no grant.
- In_ready[g] = free & Resetn; all other In_ready bits are 0.
  - At most one In_ready bit is high per cycle.
- Accept: when channel g is granted and free=1, at the clock edge:
  - Out_data <= In_data[g], Out_sel <= g, Out_valid <= 1.
  - ptr <= (g+1) mod N. Wrap: g=N-1 gives ptr=0.
- Drain: Out_ready=1 with no accept gives Out_valid <= 0. Out_data and Out_sel hold their last values.
- Stall: Out_valid=1 and Out_ready=0 means:
  - Out_data, Out_sel and ptr hold.
  - All In_ready bits are 0.
- Simultaneous drain and accept (Out_valid=1, Out_ready=1, grant present): the new word loads and Out_valid stays 1. Full throughput is 1 word/cycle.
- Latency: accepted word appears on Out_data 1 cycle after the accepting edge.
- ptr advances only on accept. Idle cycles and stalls never move it.
- Fairness: with all channels continuously valid and Out_ready=1, grants rotate 0,1,...,N-1,0, with no channel starved longer than N-1 accepts.
- Widths:
  - Data passes through unmodified, with no extension or truncation.
  - ptr and g are SEL_W bits.
  - For non-power-of-2 N, wrap is explicit compare-to-N-1, not natural overflow.

Optional Feature:
- Macro: RR_ARB_MUX_FORCE_EN.
- Defined: adds inputs Force_en (1) and Force_sel (SEL_W).
  - When Force_en=1, arbitration is bypassed and g = Force_sel (only if In_valid[Force_sel]=1, else no grant).
  - ptr does not advance on forced accepts.
  - Force_sel >= N yields no grant.
- Undefined: ports absent; pure round-robin as above.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles with In_valid=4'b1111 -> In_ready=0, Out_valid=0, Out_data=16'h0000, Out_sel=0.
- Single channel: In_valid=4'b0100, ch2=16'hBEEF, Out_ready=1 -> In_ready=4'b0100. Next cycle Out_valid=1, Out_data=16'hBEEF, Out_sel=2, ptr=3.
- Round-robin:
  - Setup: all valid with ch0..3 = 16'h1111/2222/3333/4444, Out_ready=1 for 6 cycles.
  - Out_sel sequence 0,1,2,3,0,1 on consecutive cycles; Out_data matches.
- Backpressure:
  - After ch1 = 16'hA5A5 is accepted, set Out_ready=0 for 3 cycles -> Out_data stays 16'hA5A5, In_ready=0, ptr stays 2.
  - Then set Out_ready=1 -> ch2 is accepted the same cycle and Out_valid stays 1.
- Wrap/skip: ptr=3 with In_valid=4'b0010 -> grant ch1, ptr becomes 2. Then ptr=3 with In_valid=4'b1000 -> grant ch3, ptr becomes 0.
- Reset mid-stall: Out_valid=1, Out_ready=0, pull Resetn=0 for 1 edge -> Out_valid=0, Out_data=0, ptr=0. The first grant afterward goes to the lowest valid index.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbitrating mux with valid/ready handshakes and a registered output.
// Optional RR_ARB_MUX_FORCE_EN adds Force_en/Force_sel to bypass arbitration.
module rr_arb_mux #(
   parameter  int N     = 4,
   parameter  int WIDTH = 16,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic [N-1:0]         In_valid,
   input  logic [N*WIDTH-1:0]   In_data,
   output logic [N-1:0]         In_ready,
   output logic                 Out_valid,
   output logic [WIDTH-1:0]     Out_data,
   output logic [SEL_W-1:0]     Out_sel,
   input  logic                 Out_ready
`ifdef RR_ARB_MUX_FORCE_EN
   ,
   input  logic                 Force_en,
   input  logic [SEL_W-1:0]     Force_sel
`endif
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_nxt;
   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;
   logic             free;
   logic             accept;
   logic             forced;

   assign free   = ~Out_valid | Out_ready;
   assign accept = gnt_vld & free & Resetn;

   // Scan from ptr upward with an explicit wrap so non-power-of-2 N is handled.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      gnt     = '0;
      gnt_vld = 1'b0;
      forced  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= 32'(N))
            idx = idx - 32'(N);
         if (!gnt_vld && In_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt     = SEL_W'(idx);
         end
      end
`ifdef RR_ARB_MUX_FORCE_EN
      if (Force_en) begin
         forced  = 1'b1;
         gnt     = Force_sel;
         gnt_vld = (32'(Force_sel) < 32'(N)) && In_valid[Force_sel];
      end
`endif
   end

   assign ptr_nxt = (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;

   always_comb begin
      In_ready = '0;
      if (accept)
         In_ready[gnt] = 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         Out_valid <= 1'b0;
         Out_data  <= '0;
         Out_sel   <= '0;
         ptr       <= '0;
      end else if (accept) begin
         Out_valid <= 1'b1;
         Out_data  <= In_data[32'(gnt)*WIDTH +: WIDTH];
         Out_sel   <= gnt;
         if (!forced)
            ptr <= ptr_nxt;
      end else if (Out_ready) begin
         Out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=4, WIDTH=16).
module tb_rr_arb_mux;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [3:0]  In_valid;
   logic [63:0] In_data;
   logic [3:0]  In_ready;
   logic        Out_valid;
   logic [15:0] Out_data;
   logic [1:0]  Out_sel;
   logic        Out_ready;

   int n_checks = 0;
   int n_fails  = 0;

   rr_arb_mux #(.N(4), .WIDTH(16)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .In_valid  (In_valid),
      .In_data   (In_data),
      .In_ready  (In_ready),
      .Out_valid (Out_valid),
      .Out_data  (Out_data),
      .Out_sel   (Out_sel),
      .Out_ready (Out_ready)
`ifdef RR_ARB_MUX_FORCE_EN
      ,
      .Force_en  (1'b0),
      .Force_sel (2'd0)
`endif
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Resetn    = 1'b0;
      In_valid  = 4'b1111;
      In_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      Out_ready = 1'b0;
      tick();
      tick();
      n_checks++; if (In_ready !== 4'b0000) begin n_fails++; $display("FAIL reset_in_ready: got %b expected %b", In_ready, 4'b0000); end
      n_checks++; if (Out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", Out_valid); end
      n_checks++; if (Out_data !== 16'h0000) begin n_fails++; $display("FAIL reset_out_data: got %h expected 0000", Out_data); end
      n_checks++; if (Out_sel !== 2'd0) begin n_fails++; $display("FAIL reset_out_sel: got %0d expected 0", Out_sel); end
      n_checks++; if (dut.ptr !== 2'd0) begin n_fails++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr); end
   endtask

   task automatic test_single();
      Resetn    = 1'b1;
      In_valid  = 4'b0100;
      In_data   = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
      Out_ready = 1'b1;
      #1;
      n_checks++; if (In_ready !== 4'b0100) begin n_fails++; $display("FAIL single_in_ready: got %b expected 0100", In_ready); end
      tick();
      n_checks++; if (Out_valid !== 1'b1) begin n_fails++; $display("FAIL single_out_valid: got %b expected 1", Out_valid); end
      n_checks++; if (Out_data !== 16'hBEEF) begin n_fails++; $display("FAIL single_out_data: got %h expected beef", Out_data); end
      n_checks++; if (Out_sel !== 2'd2) begin n_fails++; $display("FAIL single_out_sel: got %0d expected 2", Out_sel); end
      n_checks++; if (dut.ptr !== 2'd3) begin n_fails++; $display("FAIL single_ptr: got %0d expected 3", dut.ptr); end
      // Idle cycle with consumer ready: output drains, data and pointer hold.
      In_valid = 4'b0000;
      tick();
      n_checks++; if (Out_valid !== 1'b0) begin n_fails++; $display("FAIL drain_out_valid: got %b expected 0", Out_valid); end
      n_checks++; if (Out_data !== 16'hBEEF) begin n_fails++; $display("FAIL drain_out_data: got %h expected beef", Out_data); end
      n_checks++; if (dut.ptr !== 2'd3) begin n_fails++; $display("FAIL idle_ptr: got %0d expected 3", dut.ptr); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [3:0]  exp_rdy  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [15:0] exp_data [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222};
      Resetn = 1'b0;
      tick();
      Resetn    = 1'b1;
      In_valid  = 4'b1111;
      In_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      Out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_checks++; if (In_ready !== exp_rdy[k]) begin n_fails++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, In_ready, exp_rdy[k]); end
         tick();
         n_checks++; if (Out_valid !== 1'b1) begin n_fails++; $display("FAIL rr_out_valid[%0d]: got %b expected 1", k, Out_valid); end
         n_checks++; if (Out_sel !== exp_sel[k]) begin n_fails++; $display("FAIL rr_out_sel[%0d]: got %0d expected %0d", k, Out_sel, exp_sel[k]); end
         n_checks++; if (Out_data !== exp_data[k]) begin n_fails++; $display("FAIL rr_out_data[%0d]: got %h expected %h", k, Out_data, exp_data[k]); end
      end
   endtask

   task automatic test_backpressure();
      Resetn = 1'b0;
      tick();
      Resetn    = 1'b1;
      In_valid  = 4'b0010;
      In_data   = {16'h7777, 16'h5A5A, 16'hA5A5, 16'h0F0F};
      Out_ready = 1'b1;
      tick();
      n_checks++; if (Out_data !== 16'hA5A5) begin n_fails++; $display("FAIL bp_first_data: got %h expected a5a5", Out_data); end
      n_checks++; if (dut.ptr !== 2'd2) begin n_fails++; $display("FAIL bp_first_ptr: got %0d expected 2", dut.ptr); end
      In_valid  = 4'b1111;
      Out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (In_ready !== 4'b0000) begin n_fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, In_ready); end
         tick();
         n_checks++; if (Out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, Out_valid); end
         n_checks++; if (Out_data !== 16'hA5A5) begin n_fails++; $display("FAIL bp_out_data[%0d]: got %h expected a5a5", k, Out_data); end
         n_checks++; if (Out_sel !== 2'd1) begin n_fails++; $display("FAIL bp_out_sel[%0d]: got %0d expected 1", k, Out_sel); end
         n_checks++; if (dut.ptr !== 2'd2) begin n_fails++; $display("FAIL bp_ptr[%0d]: got %0d expected 2", k, dut.ptr); end
      end
      // Release: drain and accept in the same cycle keeps the output full.
      Out_ready = 1'b1;
      #1;
      n_checks++; if (In_ready !== 4'b0100) begin n_fails++; $display("FAIL bp_release_in_ready: got %b expected 0100", In_ready); end
      tick();
      n_checks++; if (Out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_release_valid: got %b expected 1", Out_valid); end
      n_checks++; if (Out_data !== 16'h5A5A) begin n_fails++; $display("FAIL bp_release_data: got %h expected 5a5a", Out_data); end
      n_checks++; if (Out_sel !== 2'd2) begin n_fails++; $display("FAIL bp_release_sel: got %0d expected 2", Out_sel); end
      n_checks++; if (dut.ptr !== 2'd3) begin n_fails++; $display("FAIL bp_release_ptr: got %0d expected 3", dut.ptr); end
   endtask

   task automatic test_wrap_skip();
      Out_ready = 1'b1;
      In_valid  = 4'b0010;
      #1;
      n_checks++; if (In_ready !== 4'b0010) begin n_fails++; $display("FAIL skip_in_ready: got %b expected 0010", In_ready); end
      tick();
      n_checks++; if (Out_sel !== 2'd1) begin n_fails++; $display("FAIL skip_out_sel: got %0d expected 1", Out_sel); end
      n_checks++; if (dut.ptr !== 2'd2) begin n_fails++; $display("FAIL skip_ptr: got %0d expected 2", dut.ptr); end
      In_valid = 4'b0100;
      tick();
      n_checks++; if (dut.ptr !== 2'd3) begin n_fails++; $display("FAIL wrap_setup_ptr: got %0d expected 3", dut.ptr); end
      In_valid = 4'b1000;
      #1;
      n_checks++; if (In_ready !== 4'b1000) begin n_fails++; $display("FAIL wrap_in_ready: got %b expected 1000", In_ready); end
      tick();
      n_checks++; if (Out_sel !== 2'd3) begin n_fails++; $display("FAIL wrap_out_sel: got %0d expected 3", Out_sel); end
      n_checks++; if (Out_data !== 16'h7777) begin n_fails++; $display("FAIL wrap_out_data: got %h expected 7777", Out_data); end
      n_checks++; if (dut.ptr !== 2'd0) begin n_fails++; $display("FAIL wrap_ptr: got %0d expected 0", dut.ptr); end
   endtask

   task automatic test_reset_mid_stall();
      In_valid  = 4'b0000;
      Out_ready = 1'b0;
      tick();
      n_checks++; if (Out_valid !== 1'b1) begin n_fails++; $display("FAIL stall_out_valid: got %b expected 1", Out_valid); end
      In_valid = 4'b0110;
      Resetn   = 1'b0;
      #1;
      n_checks++; if (In_ready !== 4'b0000) begin n_fails++; $display("FAIL rst_gate_in_ready: got %b expected 0000", In_ready); end
      tick();
      n_checks++; if (Out_valid !== 1'b0) begin n_fails++; $display("FAIL mid_rst_valid: got %b expected 0", Out_valid); end
      n_checks++; if (Out_data !== 16'h0000) begin n_fails++; $display("FAIL mid_rst_data: got %h expected 0000", Out_data); end
      n_checks++; if (dut.ptr !== 2'd0) begin n_fails++; $display("FAIL mid_rst_ptr: got %0d expected 0", dut.ptr); end
      Resetn    = 1'b1;
      Out_ready = 1'b1;
      #1;
      n_checks++; if (In_ready !== 4'b0010) begin n_fails++; $display("FAIL post_rst_in_ready: got %b expected 0010", In_ready); end
      tick();
      n_checks++; if (Out_sel !== 2'd1) begin n_fails++; $display("FAIL post_rst_sel: got %0d expected 1", Out_sel); end
      n_checks++; if (Out_data !== 16'hA5A5) begin n_fails++; $display("FAIL post_rst_data: got %h expected a5a5", Out_data); end
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
